// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch (i_*) and data (d_*) ports; data wins,
// with a burst cap so fetch is never starved. Optional bus timeout enabled by `define ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int D_BURST        = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_stb,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,

   input  logic        d_stb,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_sel,
   output logic        d_ack,
   output logic [31:0] d_rdata,

   output logic        m_stb,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_sel,
   input  logic        m_ack,
   input  logic [31:0] m_rdata,

   output logic [1:0]  o_grant,
   output logic        o_err
);

   localparam int BW = (D_BURST < 1) ? 1 : $clog2(D_BURST + 1);
   localparam logic [BW-1:0] BurstMax = BW'(D_BURST);
   localparam logic [31:0]   NopInsn  = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      I_BUSY = 2'b01,
      D_BUSY = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] burst_q, burst_d;
   logic          mStb_q, mStb_d;
   logic          mWe_q, mWe_d;
   logic [31:0]   mAddr_q, mAddr_d;
   logic [31:0]   mWdata_q, mWdata_d;
   logic [3:0]    mSel_q, mSel_d;
   logic [1:0]    grant_q, grant_d;
   logic          busy;
   logic          abort;
   logic          done;

   assign busy = (state_q != IDLE);
   assign done = busy && (m_ack || abort);

`ifdef ARB_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] tmo_q, tmo_d;

   // A real m_ack in the limit cycle takes precedence over the abort.
   assign abort = busy && mStb_q && !m_ack && (tmo_q == TmoLimit);

   always_comb begin
      tmo_d = '0;
      if (busy && mStb_q && !m_ack && !abort) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      burst_d  = burst_q;
      mStb_d   = mStb_q;
      mWe_d    = mWe_q;
      mAddr_d  = mAddr_q;
      mWdata_d = mWdata_q;
      mSel_d   = mSel_q;
      grant_d  = grant_q;

      case (state_q)
         IDLE: begin
            // The burst count only grows while a fetch is actually being held off.
            if (d_stb && (!i_stb || (burst_q < BurstMax))) begin
               state_d  = D_BUSY;
               burst_d  = i_stb ? (burst_q + BW'(1)) : '0;
               mStb_d   = 1'b1;
               mWe_d    = d_we;
               mAddr_d  = d_addr;
               mWdata_d = d_wdata;
               mSel_d   = d_sel;
               grant_d  = 2'b10;
            end else if (i_stb) begin
               state_d  = I_BUSY;
               burst_d  = '0;
               mStb_d   = 1'b1;
               mWe_d    = 1'b0;
               mAddr_d  = i_addr;
               mSel_d   = 4'hF;
               grant_d  = 2'b01;
            end
         end

         I_BUSY, D_BUSY: begin
            if (done) begin
               state_d = IDLE;
               mStb_d  = 1'b0;
               grant_d = 2'b00;
            end
         end

         default: begin
            state_d = IDLE;
            mStb_d  = 1'b0;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         burst_q  <= '0;
         mStb_q   <= 1'b0;
         mWe_q    <= 1'b0;
         mAddr_q  <= '0;
         mWdata_q <= '0;
         mSel_q   <= '0;
         grant_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         burst_q  <= burst_d;
         mStb_q   <= mStb_d;
         mWe_q    <= mWe_d;
         mAddr_q  <= mAddr_d;
         mWdata_q <= mWdata_d;
         mSel_q   <= mSel_d;
         grant_q  <= grant_d;
      end
   end

   assign m_stb   = mStb_q;
   assign m_we    = mWe_q;
   assign m_addr  = mAddr_q;
   assign m_wdata = mWdata_q;
   assign m_sel   = mSel_q;
   assign o_grant = grant_q;

   assign i_ack   = (state_q == I_BUSY) && (m_ack || abort);
   assign d_ack   = (state_q == D_BUSY) && (m_ack || abort);
   assign i_rdata = abort ? NopInsn : m_rdata;
   assign d_rdata = abort ? 32'h0 : m_rdata;
   assign o_err   = abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a transaction-level model with a small word memory.
module tb_mem_arbiter;

   localparam int DBurst = 4;
   localparam int Tmo    = 255;

   logic        clk;
   logic        rst;
   logic        i_stb;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_stb;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_sel;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        m_stb;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_sel;
   logic        m_ack;
   logic [31:0] m_rdata;
   logic [1:0]  o_grant;
   logic        o_err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.D_BURST(DBurst), .TIMEOUT_CYCLES(Tmo)) dut (
      .clk(clk), .rst(rst),
      .i_stb(i_stb), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
      .m_ack(m_ack), .m_rdata(m_rdata),
      .o_grant(o_grant), .o_err(o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iStb;
      logic        dStb;
      logic        dWe;
      logic [31:0] iAddr;
      logic [31:0] dAddr;
      logic [31:0] dWdata;
      logic [3:0]  dSel;
      int          lat;
      logic [31:0] rdata;
      logic [1:0]  expGrant;
   } vec_t;

   vec_t vecs[$];

   logic [31:0] physMem[8];
   logic [31:0] modelMem[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   task automatic applyStimulus(input vec_t v);
      i_stb   = v.iStb;
      i_addr  = v.iAddr;
      d_stb   = v.dStb;
      d_we    = v.dWe;
      d_addr  = v.dAddr;
      d_wdata = v.dWdata;
      d_sel   = v.dSel;
      m_ack   = 1'b0;
   endtask

   // Runs one vector from IDLE through grant, memory latency, ack and the idle cycle after it.
   task automatic runTxn(input vec_t v, input string tag);
      logic        isData;
      logic [31:0] expAddr;
      logic [3:0]  expSel;
      logic        expWe;
      isData  = (v.expGrant == 2'b10);
      expAddr = isData ? v.dAddr : v.iAddr;
      expSel  = isData ? v.dSel : 4'hF;
      expWe   = isData ? v.dWe : 1'b0;
      applyStimulus(v);
      tick();
      checkOutput({tag, "_grant"}, 32'(o_grant), 32'(v.expGrant));
      checkOutput({tag, "_mstb"}, 32'(m_stb), 32'd1);
      checkOutput({tag, "_maddr"}, m_addr, expAddr);
      checkOutput({tag, "_msel"}, 32'(m_sel), 32'(expSel));
      checkOutput({tag, "_mwe"}, 32'(m_we), 32'(expWe));
      if (isData && v.dWe) checkOutput({tag, "_mwdata"}, m_wdata, v.dWdata);
      repeat (v.lat) tick();
      checkOutput({tag, "_hold_mstb"}, 32'(m_stb), 32'd1);
      checkOutput({tag, "_hold_maddr"}, m_addr, expAddr);
      checkOutput({tag, "_noack"}, 32'({i_ack, d_ack}), 32'd0);
      m_ack   = 1'b1;
      m_rdata = v.rdata;
      #1;
      checkOutput({tag, "_iack"}, 32'(i_ack), 32'(!isData));
      checkOutput({tag, "_dack"}, 32'(d_ack), 32'(isData));
      checkOutput({tag, "_rdata"}, isData ? d_rdata : i_rdata, v.rdata);
      tick();
      m_ack   = 1'b0;
      m_rdata = 32'h0;
      if (isData) d_stb = 1'b0; else i_stb = 1'b0;
      #1;
      checkOutput({tag, "_after_mstb"}, 32'(m_stb), 32'd0);
      checkOutput({tag, "_after_grant"}, 32'(o_grant), 32'd0);
      checkOutput({tag, "_after_ack"}, 32'({i_ack, d_ack}), 32'd0);
   endtask

   initial begin
      bit          iPend;
      bit          dPend;
      logic [31:0] rIAddr;
      logic [31:0] rDAddr;
      logic [31:0] rDWdata;
      logic        rDWe;
      logic [3:0]  rDSel;
      int          streak;

      rst = 1'b1;
      i_stb = 0; i_addr = 0; d_stb = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
      m_ack = 0; m_rdata = 0;
      repeat (2) tick();
      checkOutput("rst_mstb", 32'(m_stb), 32'd0);
      checkOutput("rst_mwe", 32'(m_we), 32'd0);
      checkOutput("rst_maddr", m_addr, 32'd0);
      checkOutput("rst_mwdata", m_wdata, 32'd0);
      checkOutput("rst_msel", 32'(m_sel), 32'd0);
      checkOutput("rst_grant", 32'(o_grant), 32'd0);
      checkOutput("rst_err", 32'(o_err), 32'd0);
      rst = 1'b0;
      tick();

      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 2, 32'h00A00093, 2'b01});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h104, 32'h2000, 32'h0, 4'hF, 1, 32'h11111111, 2'b10});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 4'h0, 0, 32'h22222222, 2'b01});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0, 32'h3000, 32'hDEADBEEF, 4'h3, 3, 32'h0, 2'b10});
      for (int k = 0; k < DBurst; k++)
         vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h200, 32'h2000 + 32'(k * 4), 32'h0, 4'hF, k, 32'hA0 + 32'(k), 2'b10});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h200, 32'h2100, 32'h0, 4'hF, 1, 32'h0BADF00D, 2'b01});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h204, 32'h2104, 32'h0, 4'hF, 0, 32'h33333333, 2'b10});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h204, 32'h2108, 32'h12345678, 4'hC, 1, 32'h0, 2'b10});
      for (int k = 0; k < DBurst; k++)
         vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h204, 32'h2200 + 32'(k * 4), 32'h0, 4'h5, 1, 32'hB0 + 32'(k), 2'b10});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h204, 32'h2300, 32'h0, 4'hF, 2, 32'h44444444, 2'b01});

      foreach (vecs[n]) runTxn(vecs[n], $sformatf("vec%0d", n));

      // Reset while the data port owns the bus; the late m_ack must not be forwarded.
      i_stb = 0; d_stb = 1; d_we = 0; d_addr = 32'h4000; d_sel = 4'hF;
      tick();
      checkOutput("rstmid_grant", 32'(o_grant), 32'd2);
      rst = 1'b1;
      tick();
      checkOutput("rstmid_mstb", 32'(m_stb), 32'd0);
      checkOutput("rstmid_grant0", 32'(o_grant), 32'd0);
      checkOutput("rstmid_maddr", m_addr, 32'd0);
      rst = 1'b0; d_stb = 0; m_ack = 1'b1; m_rdata = 32'h55;
      #1;
      checkOutput("rstmid_dack", 32'(d_ack), 32'd0);
      checkOutput("rstmid_iack", 32'(i_ack), 32'd0);
      tick();
      m_ack = 1'b0;
      checkOutput("rstmid_idle", 32'(o_grant), 32'd0);
      streak = 0;

      // Randomized traffic: model picks the winner from pending requests and burst history.
      for (int k = 0; k < 8; k++) begin
         physMem[k]  = $urandom;
         modelMem[k] = physMem[k];
      end
      iPend = 0; dPend = 0;
      rIAddr = 0; rDAddr = 0; rDWdata = 0; rDWe = 0; rDSel = 0;
      for (int t = 0; t < 300; t++) begin
         logic        dataWins;
         logic [31:0] expAddr;
         logic [31:0] expRd;
         logic [2:0]  pIdx;
         if (!iPend && $urandom_range(0, 1) == 1) begin
            iPend  = 1;
            rIAddr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
         end
         if (!dPend && $urandom_range(0, 2) != 0) begin
            dPend   = 1;
            rDAddr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            rDWe    = 1'($urandom_range(0, 1));
            rDWdata = $urandom;
            rDSel   = 4'($urandom_range(1, 15));
         end
         if (!iPend && !dPend) begin
            i_stb = 0; d_stb = 0;
            m_ack = ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
            #1;
            checkOutput("rnd_idle_ack", 32'({i_ack, d_ack}), 32'd0);
            tick();
            m_ack = 1'b0;
            checkOutput("rnd_idle_grant", 32'(o_grant), 32'd0);
            continue;
         end
         dataWins = dPend && (!iPend || streak < DBurst);
         streak   = (dataWins && iPend) ? streak + 1 : 0;
         expAddr  = dataWins ? rDAddr : rIAddr;
         i_stb = iPend; i_addr = rIAddr;
         d_stb = dPend; d_addr = rDAddr; d_we = rDWe; d_wdata = rDWdata; d_sel = rDSel;
         m_ack = 0;
         tick();
         checkOutput("rnd_grant", 32'(o_grant), dataWins ? 32'd2 : 32'd1);
         checkOutput("rnd_maddr", m_addr, expAddr);
         checkOutput("rnd_msel", 32'(m_sel), dataWins ? 32'(rDSel) : 32'hF);
         checkOutput("rnd_mwe", 32'(m_we), 32'(dataWins && rDWe));
         repeat ($urandom_range(0, 3)) tick();
         checkOutput("rnd_hold_mstb", 32'(m_stb), 32'd1);
         expRd = modelMem[expAddr[4:2]];
         pIdx = m_addr[4:2];
         m_rdata = physMem[pIdx];
         if (m_we) physMem[pIdx] = mergeBytes(physMem[pIdx], m_wdata, m_sel);
         m_ack = 1'b1;
         #1;
         checkOutput("rnd_iack", 32'(i_ack), 32'(!dataWins));
         checkOutput("rnd_dack", 32'(d_ack), 32'(dataWins));
         checkOutput("rnd_err", 32'(o_err), 32'd0);
         if (!(dataWins && rDWe)) checkOutput("rnd_rdata", dataWins ? d_rdata : i_rdata, expRd);
         if (dataWins && rDWe) modelMem[expAddr[4:2]] = mergeBytes(modelMem[expAddr[4:2]], rDWdata, rDSel);
         tick();
         m_ack = 1'b0;
         if (dataWins) begin dPend = 0; d_stb = 0; end
         else begin iPend = 0; i_stb = 0; end
         checkOutput("rnd_after_mstb", 32'(m_stb), 32'd0);
      end
      i_stb = 0; d_stb = 0;
      tick();

      // Data requester withdraws stb after the grant; the transaction still completes.
      d_stb = 1; d_we = 0; d_addr = 32'h5000; d_sel = 4'hF;
      tick();
      checkOutput("drop_grant", 32'(o_grant), 32'd2);
      d_stb = 0;
      repeat (2) tick();
      checkOutput("drop_mstb", 32'(m_stb), 32'd1);
      checkOutput("drop_maddr", m_addr, 32'h5000);
      m_ack = 1'b1; m_rdata = 32'h12345678;
      #1;
      checkOutput("drop_dack", 32'(d_ack), 32'd1);
      checkOutput("drop_rdata", d_rdata, 32'h12345678);
      tick();
      m_ack = 1'b0;
      checkOutput("drop_after", 32'(m_stb), 32'd0);

      // Fetch that the memory never acks.
      i_stb = 1; i_addr = 32'h300; m_rdata = 32'hFFFFFFFF;
      tick();
      checkOutput("tmo_grant", 32'(o_grant), 32'd1);
      repeat (Tmo) tick();
`ifdef ARB_TIMEOUT_EN
      checkOutput("tmo_iack", 32'(i_ack), 32'd1);
      checkOutput("tmo_err", 32'(o_err), 32'd1);
      checkOutput("tmo_nop", i_rdata, 32'h00000013);
      checkOutput("tmo_dack", 32'(d_ack), 32'd0);
      tick();
      i_stb = 0;
      checkOutput("tmo_mstb", 32'(m_stb), 32'd0);
      checkOutput("tmo_grant0", 32'(o_grant), 32'd0);
`else
      checkOutput("notmo_mstb", 32'(m_stb), 32'd1);
      checkOutput("notmo_iack", 32'(i_ack), 32'd0);
      checkOutput("notmo_err", 32'(o_err), 32'd0);
      m_ack = 1'b1; m_rdata = 32'h0000ABCD;
      #1;
      checkOutput("notmo_late_iack", 32'(i_ack), 32'd1);
      checkOutput("notmo_late_rdata", i_rdata, 32'h0000ABCD);
      checkOutput("notmo_late_err", 32'(o_err), 32'd0);
      tick();
      m_ack = 1'b0; i_stb = 0;
      checkOutput("notmo_after", 32'(m_stb), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
